// File: rtl/reminder_pkg.sv
// reminder_pkg: types and default timing constants shared by the reminder
// block and the reminder_alert front end.
//   alert_state_t        - alert FSM states
//   *_DEF localparams    - default parameter values for the alert path
package reminder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLINK,
        ESCALATE,
        SNOOZE
    } alert_state_t;

    localparam int BLINK_HALF_DEF      = 8;
    localparam int ESCALATE_BLINKS_DEF = 4;
    localparam int SNOOZE_CYCLES_DEF   = 64;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/reminder_alert_ack_debounce.sv
// ack_debounce: conditions the raw acknowledge pushbutton.
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   raw    in  asynchronous, bouncy button (active-high)
//   level  out debounced button level
//   pulse  out one-cycle pulse on the 0->1 transition of level
// The debounced level only changes after DEBOUNCE_CYCLES consecutive
// synchronized samples disagree with it; any agreeing sample restarts the
// count. Press-to-pulse latency is 2 + DEBOUNCE_CYCLES cycles.
module ack_debounce
    import reminder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);

    logic         sync1;
    logic         sync2;
    logic [W-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            pulse      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync2;
                    stable_cnt <= '0;
                    // Pulse is registered alongside the level flip, rising only.
                    pulse      <= sync2;
                end else begin
                    stable_cnt <= stable_cnt + W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/reminder_alert.sv
// reminder_alert: turns the reminder request level into a blinking LED that
// escalates to LED plus buzzer if ignored; a debounced acknowledge press
// snoozes the alert for SNOOZE_CYCLES cycles.
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   remind    in  reminder request level
//   ack_btn   in  raw acknowledge pushbutton
//   led       out alert LED
//   buzzer    out alert buzzer
//   alerting  out high in BLINK or ESCALATE
//   snoozed   out high in SNOOZE
module reminder_alert
    import reminder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int BLINK_HALF      = BLINK_HALF_DEF,
    parameter int ESCALATE_BLINKS = ESCALATE_BLINKS_DEF,
    parameter int SNOOZE_CYCLES   = SNOOZE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic remind,
    input  logic ack_btn,
    output logic led,
    output logic buzzer,
    output logic alerting,
    output logic snoozed
);

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(2 * BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(BLINK_HALF);
    localparam logic [CNT_W-1:0] BLINKS     = CNT_W'(ESCALATE_BLINKS);
    localparam logic [CNT_W-1:0] SNZ_INIT   = CNT_W'(SNOOZE_CYCLES - 1);

    logic ack_pulse;
    logic ack_level_unused;

    ack_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ack (
        .clk   (clk),
        .reset (reset),
        .raw   (ack_btn),
        .level (ack_level_unused),
        .pulse (ack_pulse)
    );

    alert_state_t     state, state_n;
    logic [CNT_W-1:0] phase_cnt, phase_n;
    logic [CNT_W-1:0] blink_cnt, blink_n;
    logic [CNT_W-1:0] snooze_cnt, snooze_n;
    logic             led_n, buzzer_n, alerting_n, snoozed_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            blink_cnt  <= '0;
            snooze_cnt <= '0;
            led        <= 1'b0;
            buzzer     <= 1'b0;
            alerting   <= 1'b0;
            snoozed    <= 1'b0;
        end else begin
            state      <= state_n;
            phase_cnt  <= phase_n;
            blink_cnt  <= blink_n;
            snooze_cnt <= snooze_n;
            led        <= led_n;
            buzzer     <= buzzer_n;
            alerting   <= alerting_n;
            snoozed    <= snoozed_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase_cnt;
        blink_n  = blink_cnt;
        snooze_n = snooze_cnt;

        unique case (state)
            IDLE: begin
                // An ack press here is deliberately ignored.
                if (remind) begin
                    state_n = BLINK;
                    phase_n = '0;
                    blink_n = '0;
                end
            end
            BLINK, ESCALATE: begin
                if (!remind) begin
                    state_n = IDLE;
                    phase_n = '0;
                    blink_n = '0;
                end else if (ack_pulse) begin
                    state_n  = SNOOZE;
                    phase_n  = '0;
                    blink_n  = '0;
                    snooze_n = SNZ_INIT;
                end else if (phase_cnt == PHASE_LAST) begin
                    // End of an off-phase closes one blink period.
                    phase_n = '0;
                    if (state == BLINK) begin
                        if (blink_cnt + CNT_W'(1) == BLINKS) begin
                            state_n = ESCALATE;
                            blink_n = '0;
                        end else begin
                            blink_n = blink_cnt + CNT_W'(1);
                        end
                    end
                end else begin
                    phase_n = phase_cnt + CNT_W'(1);
                end
            end
            SNOOZE: begin
                if (snooze_cnt == '0) begin
                    state_n = remind ? BLINK : IDLE;
                    phase_n = '0;
                    blink_n = '0;
                end else begin
                    snooze_n = snooze_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n  = IDLE;
                phase_n  = '0;
                blink_n  = '0;
                snooze_n = '0;
            end
        endcase

        // Outputs are derived from the next state so they register on the
        // same edge as the transition.
        alerting_n = (state_n == BLINK) || (state_n == ESCALATE);
        snoozed_n  = (state_n == SNOOZE);
        led_n      = alerting_n && (phase_n < HALF);
        buzzer_n   = (state_n == ESCALATE) && led_n;
    end

endmodule

// File: tb/tb_reminder_alert.sv
// Randomized scoreboard bench for reminder_alert: a time-based reference
// model predicts the outputs after every clock edge; a monitor compares.
module tb_reminder_alert;

    localparam int DC = 4;
    localparam int BH = 8;
    localparam int EB = 4;
    localparam int SC = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic remind = 1'b0;
    logic ack_btn = 1'b0;
    logic led, buzzer, alerting, snoozed;

    always #5 clk = ~clk;

    reminder_alert #(
        .DEBOUNCE_CYCLES(DC),
        .BLINK_HALF     (BH),
        .ESCALATE_BLINKS(EB),
        .SNOOZE_CYCLES  (SC),
        .CNT_W          (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .remind  (remind),
        .ack_btn (ack_btn),
        .led     (led),
        .buzzer  (buzzer),
        .alerting(alerting),
        .snoozed (snoozed)
    );

    // Expected {led, buzzer, alerting, snoozed} after each edge.
    logic [3:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: alert timing is tracked as the age of the alert in
    // cycles, snooze as remaining snoozed cycles.
    bit m_alert;
    int m_age;
    int m_snz;
    bit m_raw_d1, m_raw_d2;
    bit m_win[DC];
    bit m_lvl;
    bit m_pls;

    task automatic model_edge(input bit r, input bit a, input bit rst);
        bit s;
        bit all_diff;
        if (rst) begin
            m_alert = 0; m_age = 0; m_snz = 0;
            m_raw_d1 = 0; m_raw_d2 = 0; m_lvl = 0; m_pls = 0;
            for (int i = 0; i < DC; i++) m_win[i] = 0;
            return;
        end
        // Alert behaviour sees the ack pulse produced one edge earlier.
        if (m_snz > 0) begin
            if (m_snz == 1) begin
                m_snz = 0;
                if (r) begin m_alert = 1; m_age = 0; end
            end else begin
                m_snz--;
            end
        end else if (m_alert) begin
            if (!r) m_alert = 0;
            else if (m_pls) begin m_alert = 0; m_snz = SC; end
            else m_age++;
        end else if (r) begin
            m_alert = 1; m_age = 0;
        end
        // Button: two-cycle delay, then a window of the last DC samples.
        s = m_raw_d2;
        m_raw_d2 = m_raw_d1;
        m_raw_d1 = a;
        for (int i = DC - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = s;
        all_diff = 1;
        for (int i = 0; i < DC; i++) if (m_win[i] == m_lvl) all_diff = 0;
        m_pls = all_diff && !m_lvl;
        if (all_diff) begin
            m_lvl = ~m_lvl;
            // Samples before a flip must not count toward the next one.
            for (int i = 0; i < DC; i++) m_win[i] = m_lvl;
        end
    endtask

    function automatic logic [3:0] model_out();
        bit l;
        l = m_alert && ((m_age % (2 * BH)) < BH);
        return {l, l && (m_age >= 2 * BH * EB), m_alert, m_snz > 0};
    endfunction

    task automatic step(input bit r, input bit a, input bit rst);
        @(negedge clk);
        reset = rst; remind = r; ack_btn = a;
        model_edge(r, a, rst);
        exp_q.push_back(model_out());
    endtask

    // Monitor: outputs are presented every cycle, one expectation per edge.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({led, buzzer, alerting, snoozed} !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t led/buzzer/alerting/snoozed got=%b required=%b",
                             $time, {led, buzzer, alerting, snoozed}, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, press_at, len;
        bit r, a, rst;

        repeat (3) step(0, 0, 1);

        // Plain alert through escalation.
        repeat (70) step(1, 0, 0);
        step(0, 0, 0);
        repeat (3) step(0, 0, 0);

        // Remind dropped mid-blink.
        repeat (20) step(1, 0, 0);
        repeat (4) step(0, 0, 0);

        // Bouncy ack then held; snooze expires with remind still high.
        repeat (5) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, (i % 2) == 0, 0);
        repeat (10) step(1, 1, 0);
        repeat (80) step(1, 0, 0);

        // Snooze entered, remind dropped during snooze.
        repeat (3) step(0, 0, 0);
        repeat (10) step(1, 0, 0);
        repeat (8) step(1, 1, 0);
        repeat (10) step(0, 0, 0);
        repeat (70) step(0, 0, 0);

        // Remind falls on the same edge the ack pulse is consumed.
        repeat (10) step(1, 0, 0);
        repeat (6) step(1, 1, 0);
        step(0, 1, 0);
        repeat (10) step(0, 0, 0);

        // Ack in idle is dropped.
        repeat (8) step(0, 1, 0);
        repeat (6) step(0, 0, 0);
        repeat (20) step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // Reset in ESCALATE, then in SNOOZE.
        repeat (70) step(1, 0, 0);
        step(1, 0, 1);
        repeat (5) step(1, 0, 0);
        repeat (6) step(1, 1, 0);
        repeat (10) step(1, 0, 0);
        step(1, 0, 1);
        repeat (20) step(1, 0, 0);

        // Randomized segments.
        for (int seg = 0; seg < 60; seg++) begin
            r = ($urandom_range(0, 3) != 0);
            n = $urandom_range(5, 80);
            press_at = $urandom_range(4, 40);
            len = $urandom_range(2, 10);
            for (int j = 0; j < n; j++) begin
                if (j >= press_at && j < press_at + len) a = 1;
                else if (j >= press_at - 4 && j < press_at) a = $urandom_range(0, 1) != 0;
                else a = 0;
                rst = ($urandom_range(0, 299) == 0);
                step(r, a, rst);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
